wb_stage_regfile: RTL
=====================

WB_STAGE_REGFILE -- requirements
Module: wb_stage_regfile

Interface
REQ-001 Parameter: DATA_W, default 16, register data width.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hold the EX/WB register and suppress commit.
REQ-006 flush  input  1  squash the instruction entering EX/WB.
REQ-007 EX_regWrite  input  1  EX-stage instruction writes a register.
REQ-008 EX_Rd  input  3  EX-stage destination register.
REQ-009 EX_result  input  DATA_W  EX-stage result.
REQ-010 EX_WB_regWrite  output  1  registered write-enable of the WB-stage instruction, driven to the forwarding unit.
REQ-011 EX_WB_Rd_out  output  3  registered destination of the WB-stage instruction.
REQ-012 EX_WB_data_out  output  DATA_W  registered result of the WB-stage instruction, used as the forwarding source.
REQ-013 rd_addr_a, rd_addr_b  input  3 each  read addresses.
REQ-014 rd_data_a, rd_data_b  output  DATA_W each  combinational read data.
REQ-015 commit_cnt  output  8  count of committed register writes.

Function
REQ-016 Storage: 8 x DATA_W registers, R1..R7 writable. R0 SHALL read as 0 at all times.
REQ-017 EX/WB register update on rising clk:
  - flush=1 -> EX_WB_regWrite<=0, Rd and data <=0. flush overrides stall.
  - else stall=1 -> all three fields hold.
  - else -> EX_WB_regWrite<=EX_regWrite & (EX_Rd!=0); EX_WB_Rd_out<=EX_Rd; EX_WB_data_out<=EX_result.
REQ-018 A write to R0 SHALL enter WB with EX_WB_regWrite=0, so the forwarding unit never matches R0.
REQ-019 Commit: on rising clk with EX_WB_regWrite=1 and stall=0, regs[EX_WB_Rd_out]<=EX_WB_data_out and commit_cnt increments by 1. Latency is one cycle from EX sample to WB output and one more cycle to architectural commit.
REQ-020 While stall=1, no commit occurs. The held instruction commits exactly once, on the first edge with stall=0.
REQ-021 A flush edge with stall=0 still commits the instruction already in WB, then clears WB. With stall=1 the flush discards the held instruction without committing it.
REQ-022 Read ports (each independently):
  - addr==0 -> 0.
  - else if EX_WB_regWrite=1 and EX_WB_Rd_out==addr -> EX_WB_data_out (write-through bypass, regardless of stall).
  - else -> regs[addr].
REQ-023 commit_cnt wraps from 255 to 0 with no flag.
REQ-024 Back-to-back writes to the same Rd SHALL commit in order; the last value wins.
REQ-025 All outputs SHALL be free of X after reset; no latches.

Reset
REQ-026 When reset is asserted, the block SHALL immediately (asynchronously) force to 0: all registers, EX_WB_regWrite, EX_WB_Rd_out, EX_WB_data_out and commit_cnt.
REQ-027 Reset asserted mid-stall SHALL discard the pending instruction with no commit. Normal operation resumes on the first edge after deassertion.

Verification
REQ-028 Basic write: write R3=0x1234 (EX_regWrite=1) -> next cycle EX_WB_regWrite=1, EX_WB_Rd_out=3 and rd_data_a(addr 3)=0x1234 via bypass; the following cycle regs[3]=0x1234 and commit_cnt=1.
REQ-029 R0 write: EX_Rd=0, EX_result=0xFFFF -> EX_WB_regWrite=0, rd_data(0)=0, commit_cnt unchanged.
REQ-030 Stall: write R5=0x00AA then hold stall for 3 cycles -> WB outputs hold, commit_cnt unchanged, bypass returns 0x00AA; after release exactly one commit occurs.
REQ-031 Flush priority: stall=1 and flush=1 with R2=0x0055 pending in WB -> EX_WB_regWrite=0 and R2 keeps its old value.
REQ-032 Wrap and ordering: 256 commits -> commit_cnt=0; back-to-back writes R4=1 then R4=2 -> R4=2.
REQ-033 Async reset: assert reset between clock edges -> all outputs read 0 before the next edge.

Source files
------------

// File: rtl/wb_stage_regfile.sv
// wb_stage_regfile
// EX/WB pipeline register feeding an 8-entry architectural register file.
// The EX/WB register captures the EX-stage result one cycle after it is
// sampled. The register file commits it on the following edge. Two
// combinational read ports see the WB-stage value through a write-through
// bypass until it is committed.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          hold the EX/WB register and suppress commit
//   flush          squash the instruction entering EX/WB (overrides stall)
//   EX_regWrite    EX-stage instruction writes a register
//   EX_Rd          EX-stage destination register
//   EX_result      EX-stage result
//   EX_WB_regWrite registered write-enable of the WB-stage instruction
//   EX_WB_Rd_out   registered destination of the WB-stage instruction
//   EX_WB_data_out registered result of the WB-stage instruction
//   rd_addr_a/b    read addresses
//   rd_data_a/b    combinational read data (R0 reads as zero)
//   commit_cnt     count of committed register writes, wraps 255 -> 0
module wb_stage_regfile #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              EX_regWrite,
    input  logic [2:0]        EX_Rd,
    input  logic [DATA_W-1:0] EX_result,
    output logic              EX_WB_regWrite,
    output logic [2:0]        EX_WB_Rd_out,
    output logic [DATA_W-1:0] EX_WB_data_out,
    input  logic [2:0]        rd_addr_a,
    input  logic [2:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [7:0]        commit_cnt
);

    // Entry 0 is never written, so it stays at its reset value of zero.
    logic [DATA_W-1:0] regs [8];
    logic              do_commit;

    // Commit whenever WB holds a valid write and the pipe is not stalled.
    // A flush without stall still commits the instruction already in WB.
    assign do_commit = EX_WB_regWrite & ~stall;

    // EX/WB pipeline register: flush clears, stall holds, else capture EX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EX_WB_regWrite <= 1'b0;
            EX_WB_Rd_out   <= 3'd0;
            EX_WB_data_out <= '0;
        end else if (flush) begin
            EX_WB_regWrite <= 1'b0;
            EX_WB_Rd_out   <= 3'd0;
            EX_WB_data_out <= '0;
        end else if (!stall) begin
            // Writes to R0 enter WB disabled so forwarding never matches R0.
            EX_WB_regWrite <= EX_regWrite & (EX_Rd != 3'd0);
            EX_WB_Rd_out   <= EX_Rd;
            EX_WB_data_out <= EX_result;
        end else begin
            EX_WB_regWrite <= EX_WB_regWrite;
            EX_WB_Rd_out   <= EX_WB_Rd_out;
            EX_WB_data_out <= EX_WB_data_out;
        end
    end

    // Architectural register file write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (do_commit && (EX_WB_Rd_out != 3'd0)) begin
            regs[EX_WB_Rd_out] <= EX_WB_data_out;
        end else begin
            regs <= regs;
        end
    end

    // Commit counter; natural 8-bit wrap is intended.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_cnt <= 8'd0;
        end else if (do_commit) begin
            commit_cnt <= commit_cnt + 8'd1;
        end else begin
            commit_cnt <= commit_cnt;
        end
    end

    // Read port A: zero for R0, bypass from WB, else stored value.
    always_comb begin
        rd_data_a = '0;
        if (rd_addr_a == 3'd0) begin
            rd_data_a = '0;
        end else if (EX_WB_regWrite && (EX_WB_Rd_out == rd_addr_a)) begin
            rd_data_a = EX_WB_data_out;
        end else begin
            rd_data_a = regs[rd_addr_a];
        end
    end

    // Read port B: same rules as port A, independent address.
    always_comb begin
        rd_data_b = '0;
        if (rd_addr_b == 3'd0) begin
            rd_data_b = '0;
        end else if (EX_WB_regWrite && (EX_WB_Rd_out == rd_addr_b)) begin
            rd_data_b = EX_WB_data_out;
        end else begin
            rd_data_b = regs[rd_addr_b];
        end
    end

endmodule
